small_calc: RTL and testbench

- Multi-cycle 3-bit calculator controlled by a state machine.
- On a go request it captures two operands and an opcode, then computes add, subtract, AND or XOR.
- It presents the result with a done flag and exposes its current state for debug and verification.
- Standalone leaf block, driven by a host that supplies operands and go.

---
 rtl/small_calc_if.sv | 16 +
 rtl/small_calc.sv | 132 +++++++++++++
 tb/tb_small_calc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/small_calc_if.sv
// Host-side bundle for small_calc: operand/opcode/go requests in, result, done and state out.
interface small_calc_if #(
  parameter int DATA_W = 3,
  parameter int ST_W   = 4
);
  logic              go;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [1:0]        op;
  logic [DATA_W-1:0] out;
  logic              done;
  logic [ST_W-1:0]   cs;

  modport master (output go, in1, in2, op, input  out, done, cs);
  modport slave  (input  go, in1, in2, op, output out, done, cs);
endinterface

// File: rtl/small_calc.sv
// Multi-cycle calculator FSM: captures A, B and opcode, then computes add/sub/and/xor modulo 2^DATA_W.
// Optional CALC_HOLD_DONE_EN makes DONE sticky while go stays high (req/ack handshake).
module small_calc #(
  parameter int DATA_W = 3,
  parameter int ST_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  small_calc_if.slave  bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD_A = 4'd1,
    ST_LOAD_B = 4'd2,
    ST_DECODE = 4'd3,
    ST_ADD    = 4'd4,
    ST_SUB    = 4'd5,
    ST_AND    = 4'd6,
    ST_XOR    = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [1:0]        r_opr;
  logic [DATA_W-1:0] r_out;
  logic              r_done;
  logic              w_cap_a;
  logic              w_cap_b;
  logic              w_cap_op;
  logic              w_compute;

  // Arithmetic wraps naturally at DATA_W bits, so carries/borrows are simply dropped.
  function automatic logic [DATA_W-1:0] calc(input logic [1:0] opr,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] res;
    case (opr)
      2'b00:   res = a + b;
      2'b01:   res = a - b;
      2'b10:   res = a & b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

  // Next-state and capture-enable decode.
  always_comb begin
    w_next_state = ST_IDLE;
    w_cap_a      = 1'b0;
    w_cap_b      = 1'b0;
    w_cap_op     = 1'b0;
    w_compute    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.go) begin
          w_next_state = ST_LOAD_A;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        w_cap_a      = 1'b1;
        w_next_state = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        w_cap_b      = 1'b1;
        w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        w_cap_op = 1'b1;
        case (bus.op)
          2'b00:   w_next_state = ST_ADD;
          2'b01:   w_next_state = ST_SUB;
          2'b10:   w_next_state = ST_AND;
          default: w_next_state = ST_XOR;
        endcase
      end
      ST_ADD, ST_SUB, ST_AND, ST_XOR: begin
        w_compute    = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DONE: begin
`ifdef CALC_HOLD_DONE_EN
        if (bus.go) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, operand, result and done registers; done is registered off the next state so it tracks cs exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_a     <= {DATA_W{1'b0}};
      r_b     <= {DATA_W{1'b0}};
      r_opr   <= 2'b00;
      r_out   <= {DATA_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == ST_DONE);
      if (w_cap_a) begin
        r_a <= bus.in1;
      end
      if (w_cap_b) begin
        r_b <= bus.in2;
      end
      if (w_cap_op) begin
        r_opr <= bus.op;
      end
      if (w_compute) begin
        r_out <= calc(r_opr, r_a, r_b);
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.done = r_done;
  assign bus.cs   = ST_W'(r_state);

endmodule

// File: tb/tb_small_calc.sv
// Self-checking bench for small_calc: fixed vector table, operand isolation, reset abort,
// back-to-back go, exhaustive sweep and random ops against a plain-arithmetic model.
module tb_small_calc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  small_calc_if #(.DATA_W(3), .ST_W(4)) bus ();
  small_calc #(.DATA_W(3), .ST_W(4)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] op;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_calc(input int a, input int b, input int o);
    int r;
    case (o)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = a ^ b;
    endcase
    return 3'(((r % 8) + 8) % 8);
  endfunction

  // One full operation from IDLE: checks the state walk, result at DONE and the return to IDLE.
  task automatic do_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] o,
                       input logic [2:0] exp, input bit perturb, input string name);
    int seq_exp[5];
    seq_exp[0] = 1; seq_exp[1] = 2; seq_exp[2] = 3; seq_exp[3] = 4 + int'(o); seq_exp[4] = 8;
    @(negedge clk);
    check({name, " idle"}, 32'(bus.cs), 32'd0);
    bus.go = 1'b1; bus.in1 = a; bus.in2 = b; bus.op = o;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (s == 0) bus.go = 1'b0;
      check($sformatf("%s cs step%0d", name, s), 32'(bus.cs), 32'(seq_exp[s]));
      if (perturb && bus.cs == 4'd2) bus.in1 = 3'd0;
      if (perturb && bus.cs == 4'd4) begin
        bus.op  = 2'b11;
        bus.in2 = 3'd0;
      end
    end
    check({name, " out@done"}, 32'(bus.out), 32'(exp));
    check({name, " done@done"}, 32'(bus.done), 32'd1);
    @(negedge clk);
    check({name, " cs after"}, 32'(bus.cs), 32'd0);
    check({name, " done after"}, 32'(bus.done), 32'd0);
    check({name, " out held"}, 32'(bus.out), 32'(exp));
  endtask

  initial begin
    int pat[6];
    logic [2:0] ra, rb;
    logic [1:0] ro;

    vecs[0] = '{3'd6, 3'd5, 2'b00, 3'd3};
    vecs[1] = '{3'd2, 3'd5, 2'b01, 3'd5};
    vecs[2] = '{3'd7, 3'd3, 2'b01, 3'd4};
    vecs[3] = '{3'd6, 3'd3, 2'b10, 3'd2};
    vecs[4] = '{3'd6, 3'd3, 2'b11, 3'd5};
    vecs[5] = '{3'd7, 3'd7, 2'b00, 3'd6};
    vecs[6] = '{3'd0, 3'd1, 2'b01, 3'd7};
    vecs[7] = '{3'd7, 3'd0, 2'b10, 3'd0};
    vecs[8] = '{3'd5, 3'd5, 2'b11, 3'd0};
    vecs[9] = '{3'd0, 3'd0, 2'b00, 3'd0};

    rst = 1'b0; bus.go = 1'b0; bus.in1 = 3'd0; bus.in2 = 3'd0; bus.op = 2'b00;
    repeat (2) @(negedge clk);
    check("reset cs", 32'(bus.cs), 32'd0);
    check("reset out", 32'(bus.out), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle without go", 32'(bus.cs), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
    end

    do_op(3'd6, 3'd5, 2'b00, 3'd3, 1'b1, "isolation");

    // Abort in the middle of an ADD: out must drop to 0 without any clock edge.
    @(negedge clk);
    bus.go = 1'b1; bus.in1 = 3'd1; bus.in2 = 3'd1; bus.op = 2'b00;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-abort cs", 32'(bus.cs), 32'd4);
    check("pre-abort out", 32'(bus.out), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("abort cs", 32'(bus.cs), 32'd0);
    check("abort out", 32'(bus.out), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post-abort idle", 32'(bus.cs), 32'd0);
    end

    // go held high continuously.
    bus.go = 1'b1; bus.in1 = 3'd1; bus.in2 = 3'd2; bus.op = 2'b00;
`ifdef CALC_HOLD_DONE_EN
    pat[0] = 1; pat[1] = 2; pat[2] = 3; pat[3] = 4; pat[4] = 8; pat[5] = 8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold walk", 32'(bus.cs), 32'(pat[i]));
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold cs", 32'(bus.cs), 32'd8);
      check("hold done", 32'(bus.done), 32'd1);
      check("hold out", 32'(bus.out), 32'd3);
    end
    bus.go = 1'b0;
    @(negedge clk);
    check("release cs", 32'(bus.cs), 32'd0);
    check("release done", 32'(bus.done), 32'd0);
`else
    pat[0] = 1; pat[1] = 2; pat[2] = 3; pat[3] = 4; pat[4] = 8; pat[5] = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("b2b cs", 32'(bus.cs), 32'(pat[i % 6]));
      check("b2b done", 32'(bus.done), (pat[i % 6] == 8) ? 32'd1 : 32'd0);
    end
    bus.go = 1'b0;
    check("b2b out", 32'(bus.out), 32'd3);
`endif

    for (int o = 0; o < 4; o++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          do_op(3'(a), 3'(b), 2'(o), ref_calc(a, b, o), 1'b0,
                $sformatf("sweep op%0d a%0d b%0d", o, a, b));
        end
      end
    end

    for (int i = 0; i < 40; i++) begin
      ra = 3'($urandom_range(7, 0));
      rb = 3'($urandom_range(7, 0));
      ro = 2'($urandom_range(3, 0));
      do_op(ra, rb, ro, ref_calc(int'(ra), int'(rb), int'(ro)), 1'($urandom_range(1, 0)) & (ro == 2'b00),
            $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
